// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner of an 8:1 mux select with hold-limit preemption
module mux8_rr_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [7:0] HMAX = 8'(HOLD_MAX);
    state_t state_q, state_d;
    logic [7:0] gnt_q, gnt_d, hold_q, hold_d;
    logic [2:0] sel_q, sel_d, ptr_q, ptr_d;
    logic busy_q, busy_d;
    logic [7:0] others, rot;
    logic [15:0] dbl;
    logic [2:0] start, idx, win;
    logic found, own, take;
    always_comb begin
        others = req & ~gnt_q;
        start = ptr_q + 3'd1;
        dbl = {others, others} >> start;
        rot = dbl[7:0];
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) idx = rot[i] ? 3'(i) : idx;
        win = idx + start;
        found = |others;
        own = |(req & gnt_q);
        take = found && (!own || hold_q == HMAX);
    end
    // ptr always tracks the owner, so one search from ptr+1 serves IDLE, release and preempt
    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        sel_d = sel_q;
        ptr_d = ptr_q;
        hold_d = hold_q;
        busy_d = busy_q;
        if (take) begin
            state_d = GRANT;
            gnt_d = 8'd1 << win;
            sel_d = win;
            ptr_d = win;
            hold_d = 8'd1;
            busy_d = 1'b1;
        end else if (!own) begin
            state_d = IDLE;
            gnt_d = 8'd0;
            busy_d = 1'b0;
        end else begin
            hold_d = hold_q < HMAX ? hold_q + 8'd1 : hold_q;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q <= 8'd0;
            sel_q <= 3'd0;
            ptr_q <= 3'd7;
            hold_q <= 8'd0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            sel_q <= sel_d;
            ptr_q <= ptr_d;
            hold_q <= hold_d;
            busy_q <= busy_d;
        end
    end
    assign gnt = gnt_q;
    assign sel = sel_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: scoreboard bench for HOLD_MAX=4 and HOLD_MAX=1 arbiters
module tb_mux8_rr_arbiter;
    typedef struct packed {
        logic [7:0] g;
        logic [2:0] s;
        logic       b;
    } exp_t;
    logic clk = 1'b0;
    logic rst, rst1;
    logic [7:0] req, req1, gnt, gnt1;
    logic [2:0] sel, sel1;
    logic busy, busy1;
    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    mux8_rr_arbiter #(.HOLD_MAX(4)) u0 (.clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel), .busy(busy));
    mux8_rr_arbiter #(.HOLD_MAX(1)) u1 (.clk(clk), .rst(rst1), .req(req1), .gnt(gnt1), .sel(sel1), .busy(busy1));
    function automatic exp_t mk(input logic [7:0] g, input logic [2:0] s, input logic b);
        mk = '{g: g, s: s, b: b};
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            rst = (k < 2);
            req = 8'hFF;
            q.push_back(k < 2 ? mk(8'h00, 3'd0, 1'b0) : mk(8'h01, 3'd0, 1'b1));
            tick();
            e = q.pop_front();
            checks++;
            if ({gnt, sel, busy} !== e) begin
                errors++;
                $display("FAIL reset k=%0d got gnt=%h sel=%0d busy=%b exp gnt=%h sel=%0d busy=%b", k, gnt, sel, busy, e.g, e.s, e.b);
            end
        end
    endtask
    task automatic test_contention;
        logic [2:0] s;
        rst = 1'b1;
        req = 8'hFF;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 33; k++) begin
            s = 3'((k / 4) % 8);
            q.push_back(mk(8'd1 << s, s, 1'b1));
            tick();
            e = q.pop_front();
            checks++;
            if ({gnt, sel, busy} !== e) begin
                errors++;
                $display("FAIL contention k=%0d got gnt=%h sel=%0d busy=%b exp gnt=%h sel=%0d busy=%b", k, gnt, sel, busy, e.g, e.s, e.b);
            end
        end
    endtask
    task automatic test_single_and_rr;
        logic [7:0] stim [16];
        exp_t ex [16];
        rst = 1'b1;
        req = 8'h00;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            stim[k] = 8'h20;
            ex[k] = mk(8'h20, 3'd5, 1'b1);
        end
        stim[10] = 8'h00; ex[10] = mk(8'h00, 3'd5, 1'b0);
        stim[11] = 8'h48; ex[11] = mk(8'h40, 3'd6, 1'b1);
        stim[12] = 8'h48; ex[12] = mk(8'h40, 3'd6, 1'b1);
        stim[13] = 8'h08; ex[13] = mk(8'h08, 3'd3, 1'b1);
        stim[14] = 8'h08; ex[14] = mk(8'h08, 3'd3, 1'b1);
        stim[15] = 8'h00; ex[15] = mk(8'h00, 3'd3, 1'b0);
        for (int k = 0; k < 16; k++) begin
            req = stim[k];
            q.push_back(ex[k]);
            tick();
            e = q.pop_front();
            checks++;
            if ({gnt, sel, busy} !== e) begin
                errors++;
                $display("FAIL single_rr k=%0d got gnt=%h sel=%0d busy=%b exp gnt=%h sel=%0d busy=%b", k, gnt, sel, busy, e.g, e.s, e.b);
            end
        end
    endtask
    task automatic test_reset_mid;
        logic [7:0] stim [4];
        logic rs [4];
        exp_t ex [4];
        rst = 1'b1;
        req = 8'h00;
        tick();
        rst = 1'b0;
        stim[0] = 8'h10; rs[0] = 1'b0; ex[0] = mk(8'h10, 3'd4, 1'b1);
        stim[1] = 8'h10; rs[1] = 1'b0; ex[1] = mk(8'h10, 3'd4, 1'b1);
        stim[2] = 8'h14; rs[2] = 1'b1; ex[2] = mk(8'h00, 3'd0, 1'b0);
        stim[3] = 8'h14; rs[3] = 1'b0; ex[3] = mk(8'h04, 3'd2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            req = stim[k];
            rst = rs[k];
            q.push_back(ex[k]);
            tick();
            e = q.pop_front();
            checks++;
            if ({gnt, sel, busy} !== e) begin
                errors++;
                $display("FAIL reset_mid k=%0d got gnt=%h sel=%0d busy=%b exp gnt=%h sel=%0d busy=%b", k, gnt, sel, busy, e.g, e.s, e.b);
            end
        end
        rst = 1'b0;
        req = 8'h00;
    endtask
    task automatic test_fast_rotation;
        logic [2:0] s;
        rst1 = 1'b1;
        req1 = 8'h81;
        q.push_back(mk(8'h00, 3'd0, 1'b0));
        tick();
        rst1 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k < 9) begin
                s = (k % 2 == 1) ? 3'd7 : 3'd0;
                req1 = 8'h81;
            end else begin
                s = 3'd1;
                req1 = 8'h02;
            end
            if (k > 0 || 1'b1) q.push_back(mk(8'd1 << s, s, 1'b1));
            e = q.pop_front();
            checks++;
            if (k == 0 && {gnt1, sel1, busy1} !== e) begin
                errors++;
                $display("FAIL fast_reset got gnt=%h sel=%0d busy=%b exp gnt=%h sel=%0d busy=%b", gnt1, sel1, busy1, e.g, e.s, e.b);
            end
            tick();
            e = q.pop_front();
            checks++;
            if ({gnt1, sel1, busy1} !== e) begin
                errors++;
                $display("FAIL fast k=%0d got gnt=%h sel=%0d busy=%b exp gnt=%h sel=%0d busy=%b", k, gnt1, sel1, busy1, e.g, e.s, e.b);
            end
            if (k < 11) q.push_front(mk(8'h00, 3'd0, 1'b0));
        end
    endtask
    initial begin
        rst = 1'b1;
        rst1 = 1'b1;
        req = 8'h00;
        req1 = 8'h00;
        #2;
        test_reset();
        test_contention();
        test_single_and_rr();
        test_reset_mid();
        test_fast_rotation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
